// File: rtl/m_unit_arbiter.sv
// rtl/m_unit_arbiter.sv - round-robin sharing of one M-extension multiply/divide unit between requesters
// Optional watchdog on the unit handshake is enabled by defining M_ARB_TIMEOUT_EN.
module m_unit_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_instr,
    input  logic [NUM_REQ*32-1:0] req_rs1,
    input  logic [NUM_REQ*32-1:0] req_rs2,
    input  logic [NUM_REQ*5-1:0]  req_rd,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [4:0]            rsp_rd,
    output logic                  rsp_wr,
    output logic                  rsp_err,
    output logic                  mu_valid,
    output logic [31:0]           mu_instr,
    output logic [31:0]           mu_rs1,
    output logic [31:0]           mu_rs2,
    output logic [4:0]            mu_rd,
    input  logic                  mu_wr,
    input  logic [31:0]           mu_result,
    input  logic                  mu_busy,
    input  logic                  mu_ready,
    input  logic [4:0]            mu_result_dest
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [4:0]         rd_q, rd_d;
    logic               mu_valid_q, mu_valid_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [4:0]         rsp_rd_q, rsp_rd_d;
    logic               rsp_wr_q, rsp_wr_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   ptr_next;
    logic [31:0]        sel_instr;
    logic [31:0]        sel_rs1;
    logic [31:0]        sel_rs2;
    logic [4:0]         sel_rd;
    logic               sel_is_m;
    logic [NUM_REQ-1:0] req_ready_c;
    logic               timeout_hit;

    // Busy is advisory only; completion is signalled solely by mu_ready.
    logic unused_mu_busy;
    assign unused_mu_busy = mu_busy;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requesting port at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign ptr_next  = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
    assign sel_instr = req_instr[int'(grant_idx)*32 +: 32];
    assign sel_rs1   = req_rs1[int'(grant_idx)*32 +: 32];
    assign sel_rs2   = req_rs2[int'(grant_idx)*32 +: 32];
    assign sel_rd    = req_rd[int'(grant_idx)*5 +: 5];
    assign sel_is_m  = (sel_instr[6:0] == 7'b0110011) && (sel_instr[31:25] == 7'b0000001);

`ifdef M_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Zero outside ISSUE/WAIT, so every operation starts its count from zero.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        mu_valid_d  = mu_valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        req_ready_c = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    ptr_d   = ptr_next;
                    instr_d = sel_instr;
                    rs1_d   = sel_rs1;
                    rs2_d   = sel_rs2;
                    rd_d    = sel_rd;
                    if (sel_is_m) begin
                        mu_valid_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        rsp_valid_d = onehot(grant_idx);
                        rsp_data_d  = 32'h0;
                        rsp_rd_d    = sel_rd;
                        rsp_wr_d    = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                // A completion in the same cycle as the watchdog expiry takes priority.
                if (mu_ready) begin
                    mu_valid_d  = 1'b0;
                    rsp_valid_d = onehot(owner_q);
                    rsp_data_d  = mu_result;
                    rsp_rd_d    = mu_result_dest;
                    rsp_wr_d    = mu_wr;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (timeout_hit) begin
                    mu_valid_d  = 1'b0;
                    rsp_valid_d = onehot(owner_q);
                    rsp_data_d  = 32'hDEAD_0000;
                    rsp_rd_d    = rd_q;
                    rsp_wr_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    rsp_data_d  = 32'h0;
                    rsp_rd_d    = 5'h0;
                    rsp_wr_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            instr_q     <= 32'h0;
            rs1_q       <= 32'h0;
            rs2_q       <= 32'h0;
            rd_q        <= 5'h0;
            mu_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 32'h0;
            rsp_rd_q    <= 5'h0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            mu_valid_q  <= mu_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // An accept pulse during reset would be lost, so the grant is masked while resetn is low.
    assign req_ready = req_ready_c & {NUM_REQ{resetn}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_err   = rsp_err_q;
    assign mu_valid  = mu_valid_q;
    assign mu_instr  = instr_q;
    assign mu_rs1    = rs1_q;
    assign mu_rs2    = rs2_q;
    assign mu_rd     = rd_q;

endmodule

// File: tb/tb_m_unit_arbiter.sv
// tb/tb_m_unit_arbiter.sv - scoreboard bench for m_unit_arbiter with a behavioural M unit
module tb_m_unit_arbiter;

    localparam logic [31:0] MUL = 32'h022081B3;
    localparam logic [31:0] DIV = 32'h0220C1B3;
    localparam logic [31:0] ADD = 32'h002081B3;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_instr, req_rs1, req_rs2;
    logic [9:0]  req_rd;
    logic [31:0] rsp_data, mu_instr, mu_rs1, mu_rs2, mu_result;
    logic [4:0]  rsp_rd, mu_rd, mu_dest;
    logic        rsp_wr, rsp_err, mu_valid, mu_wr, mu_busy, mu_ready;

    logic        rv [2];
    logic [31:0] ri [2];
    logic [31:0] r1 [2];
    logic [31:0] r2 [2];
    logic [4:0]  rdv [2];

    logic        unit_on, force_ready;
    int          unit_delay;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wr;
        logic        err;
    } exp_t;

    exp_t exp_rsp [$];
    int   exp_grant [$];

    logic [31:0] t_a0 [4] = '{32'd5, 32'd12, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_b0 [4] = '{32'd5, 32'd3, 32'd9, 32'd2};
    logic [31:0] t_e0 [4] = '{32'd25, 32'd36, 32'd0, 32'hFFFFFFFE};
    logic [31:0] t_a1 [4] = '{32'd11, 32'd100, 32'h10000, 32'd3};
    logic [31:0] t_b1 [4] = '{32'd11, 32'd200, 32'h10000, 32'd7};
    logic [31:0] t_e1 [4] = '{32'd121, 32'd20000, 32'd0, 32'd21};

    assign req_valid = {rv[1], rv[0]};
    assign req_instr = {ri[1], ri[0]};
    assign req_rs1   = {r1[1], r1[0]};
    assign req_rs2   = {r2[1], r2[0]};
    assign req_rd    = {rdv[1], rdv[0]};

    m_unit_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
        .mu_valid(mu_valid), .mu_instr(mu_instr), .mu_rs1(mu_rs1), .mu_rs2(mu_rs2), .mu_rd(mu_rd),
        .mu_wr(mu_wr), .mu_result(mu_result), .mu_busy(mu_busy), .mu_ready(mu_ready),
        .mu_result_dest(mu_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int owner, input logic [31:0] data, input logic [4:0] rd,
                              input logic wr, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.rd    = rd;
        e.wr    = wr;
        e.err   = err;
        exp_rsp.push_back(e);
    endtask

    task automatic send(input int i, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
        int n;
        n      = 0;
        rv[i]  = 1'b1;
        ri[i]  = ins;
        r1[i]  = a;
        r2[i]  = b;
        rdv[i] = rd;
        @(negedge clk);
        while (!req_ready[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_req%0d: req_ready not seen within 300 cycles, expected a grant", i);
        end
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
    endtask

    task automatic drain(input string what);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_grant.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_rsp.size() != 0 || exp_grant.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d responses and %0d grants outstanding, expected 0",
                     what, exp_rsp.size(), exp_grant.size());
            exp_rsp.delete();
            exp_grant.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] unit_op(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
        case (ins[14:12])
            3'b000:  return a * b;
            3'b100:  return (b == 32'h0) ? 32'hFFFFFFFF : 32'($signed(a) / $signed(b));
            default: return a ^ b;
        endcase
    endfunction

    // Behavioural unit: answers unit_delay cycles after mu_valid rises.
    initial begin
        int   cnt;
        logic rs, pv, pr;
        cnt = 0; pv = 1'b0; pr = 1'b0;
        mu_ready = 1'b0; mu_result = 32'h0; mu_wr = 1'b0; mu_dest = 5'h0; mu_busy = 1'b0;
        forever begin
            @(posedge clk);
            rs = resetn;
            #1;
            if (unit_on && rs && pv && !pr) check("mu_valid_hold", 32'(mu_valid), 32'd1);
            mu_ready = 1'b0;
            mu_busy  = 1'b0;
            if (force_ready) begin
                mu_ready = 1'b1; mu_result = 32'h1234; mu_wr = 1'b1; mu_dest = 5'd16;
            end else if (unit_on && mu_valid) begin
                cnt++;
                if (cnt >= unit_delay) begin
                    mu_ready  = 1'b1;
                    mu_result = unit_op(mu_instr, mu_rs1, mu_rs2);
                    mu_wr     = 1'b1;
                    mu_dest   = mu_rd;
                    cnt       = 0;
                end else begin
                    mu_busy = 1'b1;
                end
            end else begin
                cnt = 0;
            end
            pv = mu_valid;
            pr = mu_ready;
        end
    end

    // Monitor: pops the scoreboard on every grant and every response handshake.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            if (resetn && req_ready != 2'b00) begin
                if (exp_grant.size() == 0) begin
                    check("grant_unexpected", 32'(req_ready), 32'd0);
                end else begin
                    g = exp_grant.pop_front();
                    check("grant", 32'(req_ready), 32'd1 << g);
                end
            end
            if (resetn && (rsp_valid & rsp_ready) != 2'b00) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_owner", 32'(rsp_valid), 32'd1 << e.owner);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_rd", 32'(rsp_rd), 32'(e.rd));
                    check("rsp_wr", 32'(rsp_wr), 32'(e.wr));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ri[i] = 32'h0; r1[i] = 32'h0; r2[i] = 32'h0; rdv[i] = 5'h0;
        end
        rsp_ready   = 2'b11;
        unit_on     = 1'b1;
        force_ready = 1'b0;
        unit_delay  = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mu_valid", 32'(mu_valid), 32'd0);
        check("rst_rsp_fields", {rsp_data[26:0], rsp_rd}, 32'd0);
        check("rst_mu_instr", mu_instr, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // MUL on requester 0: 7*6
        exp_grant.push_back(0);
        expect_rsp(0, 32'd42, 5'd3, 1'b1, 1'b0);
        send(0, MUL, 32'd7, 32'd6, 5'd3);
        @(negedge clk);
        check("mul_mu_valid", 32'(mu_valid), 32'd1);
        check("mul_mu_instr", mu_instr, MUL);
        check("mul_mu_rs1", mu_rs1, 32'd7);
        check("mul_mu_rs2", mu_rs2, 32'd6);
        check("mul_mu_rd", 32'(mu_rd), 32'd3);
        drain("mul");

        // DIV by zero on requester 1
        exp_grant.push_back(1);
        expect_rsp(1, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0);
        send(1, DIV, 32'd100, 32'd0, 5'd5);
        drain("div");

        // Both requesters busy: grants alternate 0,1,0,1,...
        for (int k = 0; k < 4; k++) begin
            exp_grant.push_back(0);
            expect_rsp(0, t_e0[k], 5'(5 + k), 1'b1, 1'b0);
            exp_grant.push_back(1);
            expect_rsp(1, t_e1[k], 5'(9 + k), 1'b1, 1'b0);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) send(0, MUL, t_a0[k], t_b0[k], 5'(5 + k));
            end
            begin
                for (int k = 0; k < 4; k++) send(1, MUL, t_a1[k], t_b1[k], 5'(9 + k));
            end
        join
        drain("alternate");

        // Non-M instruction is rejected without touching the unit
        exp_grant.push_back(0);
        expect_rsp(0, 32'd0, 5'd4, 1'b0, 1'b1);
        send(0, ADD, 32'd1, 32'd2, 5'd4);
        @(negedge clk);
        check("add_no_mu_valid", 32'(mu_valid), 32'd0);
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        drain("add");

        // Response backpressure on requester 0 while requester 1 waits
        rsp_ready = 2'b10;
        exp_grant.push_back(0);
        expect_rsp(0, 32'd72, 5'd14, 1'b1, 1'b0);
        send(0, MUL, 32'd8, 32'd9, 5'd14);
        exp_grant.push_back(1);
        expect_rsp(1, 32'd16, 5'd15, 1'b1, 1'b0);
        fork
            send(1, MUL, 32'd4, 32'd4, 5'd15);
        join_none
        n = 0;
        @(negedge clk);
        while (!rsp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", rsp_data, 32'd72);
            check("bp_rsp_rd", 32'(rsp_rd), 32'd14);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("bp_gap_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_after_gap_grant", 32'(req_ready), 32'd2);
        drain("backpressure");

        // Reset while waiting on the unit
        unit_on = 1'b0;
        exp_grant.push_back(0);
        send(0, MUL, 32'd3, 32'd3, 5'd16);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_mu_valid", 32'(mu_valid), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_mu_instr", mu_instr, 32'd0);
        check("mid_rst_mu_rs1", mu_rs1, 32'd0);
        check("mid_rst_mu_rd", 32'(mu_rd), 32'd0);
        @(posedge clk);
        #1;
        force_ready = 1'b1;
        @(posedge clk);
        #1;
        force_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_stale_ready", 32'(rsp_valid), 32'd0);
        end
        unit_on = 1'b1;
        @(posedge clk);
        #1;
        exp_grant.push_back(0);
        expect_rsp(0, 32'd6, 5'd17, 1'b1, 1'b0);
        exp_grant.push_back(1);
        expect_rsp(1, 32'd20, 5'd18, 1'b1, 1'b0);
        fork
            send(0, MUL, 32'd2, 32'd3, 5'd17);
            send(1, MUL, 32'd4, 32'd5, 5'd18);
        join
        drain("after_reset");

`ifdef M_ARB_TIMEOUT_EN
        // Unit never answers: watchdog fires after 8 cycles in ISSUE/WAIT
        unit_on = 1'b0;
        exp_grant.push_back(0);
        expect_rsp(0, 32'hDEAD_0000, 5'd19, 1'b0, 1'b1);
        send(0, MUL, 32'd1, 32'd1, 5'd19);
        n = 0;
        @(negedge clk);
        while (mu_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_mu_valid_cycles", 32'(n), 32'd8);
        drain("timeout");
        unit_on = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
